// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline stages.
// Opcodes, instruction field positions and the decoded micro-op layout.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 16;
   localparam int AW     = 4;
   localparam int OUT_W  = 5 + 4 + 1 + 2 * DATA_W;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 23;
   localparam int RS1_HI = 22;
   localparam int RS1_LO = 19;
   localparam int RS2_HI = 18;
   localparam int RS2_LO = 15;
   localparam int IMM_HI = 14;
   localparam int IMM_LO = 0;

   localparam logic [4:0] OP_MOV        = 5'b00000;
   localparam logic [4:0] OP_LD         = 5'b00001;
   localparam logic [4:0] OP_ADD        = 5'b00011;
   localparam logic [4:0] OP_SUB        = 5'b00100;
   localparam logic [4:0] OP_AND        = 5'b00101;
   localparam logic [4:0] OP_OR         = 5'b00110;
   localparam logic [4:0] OP_NOT        = 5'b00111;
   localparam logic [4:0] OP_JMP        = 5'b01000;
   localparam logic [4:0] OP_NOP        = 5'b01001;
   localparam logic [4:0] OP_OB_CHECK   = 5'b01010;
   localparam logic [4:0] OP_MOVE_LEFT  = 5'b01011;
   localparam logic [4:0] OP_MOVE_RIGHT = 5'b01100;
   localparam logic [4:0] OP_STOP       = 5'b01101;
   localparam logic [4:0] OP_CONTINUE   = 5'b01110;
   localparam logic [4:0] OP_VEL_GUARD  = 5'b01111;
   localparam logic [4:0] OP_CMP        = 5'b10000;
   localparam logic [4:0] OP_MULT       = 5'b10001;
   localparam logic [4:0] OP_DIVISION   = 5'b10010;

   typedef struct packed {
      logic [4:0]        opcode;
      logic [AW-1:0]     rd;
      logic              wb;
      logic [DATA_W-1:0] op_a;
      logic [DATA_W-1:0] op_b;
   } uop_t;

endpackage

// File: rtl/id_regfile.sv
// 16x16 register file: one write port, two combinational read ports
// with same-cycle writeback bypass, asynchronously cleared.
module id_regfile
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs [NREGS];
   logic              wr_ok;

   // Writeback is meaningless while held in reset, so bypass is gated too.
   assign wr_ok = we & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (wr_ok && waddr == raddr_a) ? wdata : regs[raddr_a];
   assign rdata_b = (wr_ok && waddr == raddr_b) ? wdata : regs[raddr_b];

endmodule

// File: rtl/id.sv
// Instruction-decode stage: field split, operand read and micro-op
// push into the ID->EX FIFO with a ready/write-enable handshake.
module id
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] WB_data,
   input  logic [AW-1:0]     WB_reg_addr,
   input  logic              WB_reg_write,
   output logic [OUT_W-1:0]  fifo_data,
   output logic              fifo_wr_en,
   input  logic              fifo_wr_ready
);

   logic [4:0]        opcode;
   logic [AW-1:0]     rd;
   logic [AW-1:0]     rs1;
   logic [AW-1:0]     rs2;
   logic [14:0]       imm;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic              legal;
   logic              wb;
   logic              use_imm;
   logic              is_nop;
   uop_t              uop;

   assign opcode = instruction[OPC_HI:OPC_LO];
   assign rd     = instruction[RD_HI:RD_LO];
   assign rs1    = instruction[RS1_HI:RS1_LO];
   assign rs2    = instruction[RS2_HI:RS2_LO];
   assign imm    = instruction[IMM_HI:IMM_LO];

   id_regfile u_rf (
      .clk     (clk),
      .rst_n   (reset),
      .we      (WB_reg_write),
      .waddr   (WB_reg_addr),
      .wdata   (WB_data),
      .raddr_a (rs1),
      .raddr_b (rs2),
      .rdata_a (rd_a),
      .rdata_b (rd_b)
   );

   always_comb begin
      legal   = 1'b1;
      wb      = 1'b0;
      use_imm = 1'b0;
      is_nop  = 1'b0;
      unique case (opcode)
         OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
         OP_MULT, OP_DIVISION, OP_OB_CHECK, OP_VEL_GUARD: wb = 1'b1;
         OP_LD: begin
            wb      = 1'b1;
            use_imm = 1'b1;
         end
         OP_JMP: use_imm = 1'b1;
         OP_CMP, OP_MOVE_LEFT, OP_MOVE_RIGHT,
         OP_STOP, OP_CONTINUE: wb = 1'b0;
         OP_NOP: is_nop = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      uop.opcode = opcode;
      uop.rd     = rd;
      uop.wb     = wb;
      uop.op_a   = rd_a;
      uop.op_b   = use_imm ? {1'b0, imm} : rd_b;
   end

   assign fifo_data  = uop;
   assign fifo_wr_en = reset & fifo_wr_ready & legal & ~is_nop;

endmodule

// File: tb/tb_id.sv
// Self-checking bench for the id decode stage: vector table plus
// a write scoreboard, with hand sequences for reset corner cases.
module tb_id;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [15:0] WB_data;
   logic [3:0]  WB_reg_addr;
   logic        WB_reg_write;
   logic [41:0] fifo_data;
   logic        fifo_wr_en;
   logic        fifo_wr_ready;

   int compared = 0;
   int failed   = 0;

   logic [41:0] sb [$];

   typedef struct {
      logic [31:0] instr;
      logic        ready;
      logic        wbw;
      logic [3:0]  wba;
      logic [15:0] wbd;
      logic        en;
      logic [41:0] data;
   } vec_t;

   vec_t tbl [$];

   id dut (
      .clk           (clk),
      .reset         (reset),
      .instruction   (instruction),
      .WB_data       (WB_data),
      .WB_reg_addr   (WB_reg_addr),
      .WB_reg_write  (WB_reg_write),
      .fifo_data     (fifo_data),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_wr_ready (fifo_wr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [4:0] op,
                                      input logic [3:0] rd,
                                      input logic [3:0] rs1,
                                      input logic [3:0] rs2,
                                      input logic [14:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   function automatic logic [41:0] pk(input logic [4:0] op,
                                      input logic [3:0] rd,
                                      input logic wb,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
      return {op, rd, wb, a, b};
   endfunction

   function automatic vec_t v(input logic [31:0] ins, input logic rdy,
                              input logic wbw, input logic [3:0] wba,
                              input logic [15:0] wbd, input logic en,
                              input logic [41:0] d);
      vec_t r;
      r.instr = ins;
      r.ready = rdy;
      r.wbw   = wbw;
      r.wba   = wba;
      r.wbd   = wbd;
      r.en    = en;
      r.data  = d;
      return r;
   endfunction

   // Every DUT write is matched against the oldest expected word.
   always @(negedge clk) begin
      if (fifo_wr_en) begin
         compared++;
         if (sb.size() == 0) begin
            failed++;
            $display("FAIL unexpected_write got=%h required=none", fifo_data);
         end else begin
            logic [41:0] e;
            e = sb.pop_front();
            if (fifo_data !== e) begin
               failed++;
               $display("FAIL write_data got=%h required=%h", fifo_data, e);
            end
         end
      end
   end

   task automatic chk_en(input string nm, input logic exp);
      compared++;
      if (fifo_wr_en !== exp) begin
         failed++;
         $display("FAIL %s wr_en got=%b required=%b", nm, fifo_wr_en, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int idx);
      @(posedge clk);
      #1;
      instruction   = t.instr;
      fifo_wr_ready = t.ready;
      WB_reg_write  = t.wbw;
      WB_reg_addr   = t.wba;
      WB_data       = t.wbd;
      if (t.en) sb.push_back(t.data);
      @(negedge clk);
      chk_en($sformatf("vec%0d", idx), t.en);
   endtask

   logic [4:0] op_nop;
   logic [4:0] op_add;

   initial begin
      op_nop = 5'b01001;
      op_add = 5'b00011;

      tbl.push_back(v(mk(op_nop, 0, 0, 0, 0), 1, 1, 1, 16'hABCD, 0, '0));
      tbl.push_back(v(mk(op_nop, 0, 0, 0, 0), 1, 1, 2, 16'h1234, 0, '0));
      tbl.push_back(v(mk(5'h00, 3, 1, 2, 0), 1, 0, 0, 0, 1, 42'h007ABCD1234));
      tbl.push_back(v(mk(5'h03, 3, 1, 2, 0), 1, 0, 0, 0, 1, 42'h067ABCD1234));
      tbl.push_back(v(mk(5'h04, 3, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h04, 3, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h05, 3, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h05, 3, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h06, 3, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h06, 3, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h07, 3, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h07, 3, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h11, 3, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h11, 3, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h12, 3, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h12, 3, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h10, 3, 1, 2, 0), 1, 0, 0, 0, 1, 42'h206ABCD1234));
      tbl.push_back(v(mk(5'h0B, 4, 0, 0, 0), 1, 0, 0, 0, 1, 42'h16800000000));
      tbl.push_back(v(mk(5'h0C, 4, 0, 0, 0), 1, 0, 0, 0, 1,
                      pk(5'h0C, 4, 0, 0, 0)));
      tbl.push_back(v(mk(5'h0D, 4, 0, 0, 0), 1, 0, 0, 0, 1,
                      pk(5'h0D, 4, 0, 0, 0)));
      tbl.push_back(v(mk(5'h0E, 4, 0, 0, 0), 1, 0, 0, 0, 1,
                      pk(5'h0E, 4, 0, 0, 0)));
      tbl.push_back(v(mk(5'h0A, 5, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h0A, 5, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h0F, 5, 1, 2, 0), 1, 0, 0, 0, 1,
                      pk(5'h0F, 5, 1, 16'hABCD, 16'h1234)));
      tbl.push_back(v(mk(5'h01, 7, 1, 2, 15'h7FFF), 1, 0, 0, 0, 1,
                      pk(5'h01, 7, 1, 16'hABCD, 16'h7FFF)));
      tbl.push_back(v(mk(5'h08, 0, 2, 1, 15'h4001), 1, 0, 0, 0, 1,
                      pk(5'h08, 0, 0, 16'h1234, 16'h4001)));
      tbl.push_back(v(mk(op_add, 3, 1, 2, 0), 0, 0, 0, 0, 0, '0));
      tbl.push_back(v(mk(op_add, 3, 1, 2, 0), 0, 0, 0, 0, 0, '0));
      tbl.push_back(v(mk(op_add, 3, 1, 2, 0), 1, 0, 0, 0, 1, 42'h067ABCD1234));
      tbl.push_back(v(mk(op_nop, 3, 1, 2, 0), 1, 0, 0, 0, 0, '0));
      tbl.push_back(v(mk(5'h1F, 3, 1, 2, 0), 1, 0, 0, 0, 0, '0));
      tbl.push_back(v(mk(5'h13, 3, 1, 2, 0), 1, 0, 0, 0, 0, '0));
      tbl.push_back(v(mk(5'h02, 3, 1, 2, 0), 1, 0, 0, 0, 0, '0));
      tbl.push_back(v(mk(op_add, 6, 5, 5, 0), 1, 1, 5, 16'h5555, 1,
                      pk(5'h03, 6, 1, 16'h5555, 16'h5555)));
      tbl.push_back(v(mk(op_nop, 0, 0, 0, 0), 1, 1, 0, 16'hBEEF, 0, '0));
      tbl.push_back(v(mk(5'h00, 8, 0, 0, 0), 1, 0, 0, 0, 1,
                      pk(5'h00, 8, 1, 16'hBEEF, 16'hBEEF)));

      reset         = 1'b0;
      instruction   = mk(op_add, 3, 1, 2, 0);
      fifo_wr_ready = 1'b1;
      WB_reg_write  = 1'b1;
      WB_reg_addr   = 4'd1;
      WB_data       = 16'hFFFF;
      repeat (2) begin
         @(negedge clk);
         chk_en("in_reset", 1'b0);
      end
      compared++;
      if (fifo_data !== pk(5'h03, 3, 1, 16'h0000, 16'h0000)) begin
         failed++;
         $display("FAIL reset_data got=%h required=%h", fifo_data,
                  pk(5'h03, 3, 1, 16'h0000, 16'h0000));
      end

      @(posedge clk);
      #1;
      reset        = 1'b1;
      WB_reg_write = 1'b0;
      instruction  = mk(5'h00, 3, 1, 2, 0);
      sb.push_back(pk(5'h00, 3, 1, 16'h0000, 16'h0000));
      @(negedge clk);
      chk_en("post_reset", 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end

      @(posedge clk);
      #1;
      WB_reg_write  = 1'b0;
      fifo_wr_ready = 1'b1;
      instruction   = mk(op_add, 3, 1, 2, 0);
      #2;
      chk_en("pre_async", 1'b1);
      reset = 1'b0;
      #1;
      chk_en("async_drop", 1'b0);
      compared++;
      if (fifo_data !== pk(5'h03, 3, 1, 16'h0000, 16'h0000)) begin
         failed++;
         $display("FAIL async_clear got=%h required=%h", fifo_data,
                  pk(5'h03, 3, 1, 16'h0000, 16'h0000));
      end

      @(posedge clk);
      #1;
      reset       = 1'b1;
      instruction = mk(5'h00, 9, 1, 8, 0);
      sb.push_back(pk(5'h00, 9, 1, 16'h0000, 16'h0000));
      @(negedge clk);
      chk_en("r1_cleared", 1'b1);

      @(posedge clk);
      #1;
      instruction = mk(op_nop, 0, 0, 0, 0);
      @(negedge clk);
      compared++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL missing_writes got=%0d required=0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, failed);
      $finish;
   end

endmodule
